// File: rtl/ram_simple2port_pipe.sv
// Simple dual-port RAM (1 read, 1 write) with per-lane write mask, fixed read latency,
// optional same-address read-during-write forwarding and a collision flag.
module ram_simple2port_pipe #(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048,
  parameter int BDLANE = 32,
  parameter int RDLAT  = 2,
  parameter int WRFWD  = 0,
  localparam int NLANE = BDWORD / BDLANE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [BDADDR-1:0] rd_addr,
  output logic [BDWORD-1:0] rd_word,
  output logic              rd_vld,
  output logic              rd_coll,
  input  logic              wr_en,
  input  logic [BDADDR-1:0] wr_addr,
  input  logic [BDWORD-1:0] wr_word,
  input  logic [NLANE-1:0]  wr_mask
);

  localparam int DEPTH = 2 ** BDADDR;

  if (BDWORD % BDLANE != 0) begin : g_chk_lane
    $error("ram_simple2port_pipe: BDWORD must be a multiple of BDLANE");
  end
  if (RDLAT < 1 || RDLAT > 4) begin : g_chk_lat
    $error("ram_simple2port_pipe: RDLAT must be in 1..4");
  end

  logic [BDWORD-1:0] r_mem [DEPTH];
  logic [BDWORD-1:0] r_rd_raw;
  logic              r_s1_vld;
  logic              r_s1_coll;
  logic [BDWORD-1:0] w_merged;
  logic              w_addr_eq;
  logic              w_coll;

  logic [BDWORD-1:0] w_stg_data [RDLAT];
  logic              w_stg_vld  [RDLAT];
  logic              w_stg_coll [RDLAT];

  assign w_addr_eq = wr_en && (wr_addr == rd_addr);
  assign w_coll    = w_addr_eq && (|wr_mask);

  // Lane-masked write; read port below sees pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_mask[i]) begin
          r_mem[wr_addr][i*BDLANE +: BDLANE] <= wr_word[i*BDLANE +: BDLANE];
        end
      end
    end
  end

  // Raw array read kept free of reset so it maps onto the RAM output register.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_raw <= r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_coll <= 1'b0;
    end else begin
      r_s1_vld  <= rd_en;
      r_s1_coll <= rd_en && w_coll;
    end
  end

  if (WRFWD != 0) begin : g_fwd
    logic [NLANE-1:0]  r_fwd_lanes;
    logic [BDWORD-1:0] r_fwd_word;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_fwd_lanes <= '0;
      end else if (rd_en) begin
        r_fwd_lanes <= w_addr_eq ? wr_mask : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rd_en) begin
        r_fwd_word <= wr_word;
      end
    end

    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      assign w_merged[gi*BDLANE +: BDLANE] = r_fwd_lanes[gi] ? r_fwd_word[gi*BDLANE +: BDLANE]
                                                              : r_rd_raw[gi*BDLANE +: BDLANE];
    end
  end else begin : g_nofwd
    assign w_merged = r_rd_raw;
  end

  // Stage 1 data is zeroed on bubbles, so later stages never carry stale words.
  assign w_stg_data[0] = r_s1_vld ? w_merged : '0;
  assign w_stg_vld[0]  = r_s1_vld;
  assign w_stg_coll[0] = r_s1_coll;

  for (genvar gi = 1; gi < RDLAT; gi++) begin : g_stg
    logic [BDWORD-1:0] r_data;
    logic              r_vld;
    logic              r_coll;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
        r_vld  <= 1'b0;
        r_coll <= 1'b0;
      end else begin
        r_data <= w_stg_data[gi-1];
        r_vld  <= w_stg_vld[gi-1];
        r_coll <= w_stg_coll[gi-1];
      end
    end

    assign w_stg_data[gi] = r_data;
    assign w_stg_vld[gi]  = r_vld;
    assign w_stg_coll[gi] = r_coll;
  end

  assign rd_vld  = w_stg_vld[RDLAT-1];
  assign rd_word = rd_vld ? w_stg_data[RDLAT-1] : '0;
  assign rd_coll = rd_vld & w_stg_coll[RDLAT-1];

endmodule

// File: tb/tb_ram_simple2port_pipe.sv
// Scoreboard bench: two instances (RDLAT=2 old-data, RDLAT=4 forwarding) share one stimulus
// stream; expected reads are queued at issue and checked by a negedge monitor.
module tb_ram_simple2port_pipe;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NL = DW / LW;
  localparam int LAT0 = 2;
  localparam int LAT1 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_word = '0;
  logic [NL-1:0] wr_mask = '0;

  logic          vld0, coll0, vld1, coll1;
  logic [DW-1:0] word0, word1;

  always #5 clk = ~clk;

  ram_simple2port_pipe #(.BDADDR(AW), .BDWORD(DW), .BDLANE(LW), .RDLAT(LAT0), .WRFWD(0)) u_old (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(word0), .rd_vld(vld0),
    .rd_coll(coll0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word), .wr_mask(wr_mask)
  );

  ram_simple2port_pipe #(.BDADDR(AW), .BDWORD(DW), .BDLANE(LW), .RDLAT(LAT1), .WRFWD(1)) u_new (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(word1), .rd_vld(vld1),
    .rd_coll(coll1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word), .wr_mask(wr_mask)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(input int k, input logic vld, input logic [DW-1:0] word, input logic coll);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : q1.size();
    while (n > 0) begin
      e = (k == 0) ? q0[0] : q1[0];
      if (e.due >= cyc) break;
      total++;
      bad++;
      $display("FAIL missed_vld[%0d]: rd_vld=0 at cycle %0d, required 1 at cycle %0d", k, cyc, e.due);
      if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
      n--;
    end
    if (vld === 1'b1) begin
      if (n == 0 || e.due != cyc) begin
        total++;
        bad++;
        $display("FAIL unexpected_vld[%0d]: rd_vld=1 at cycle %0d, required 0", k, cyc);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        $display("rd[%0d] cycle=%0d word=%h coll=%b (want %h/%b)", k, cyc, word, coll, e.data, e.coll);
        check($sformatf("rd_word[%0d]", k), word, e.data);
        check($sformatf("rd_coll[%0d]", k), {31'b0, coll}, {31'b0, e.coll});
      end
    end else begin
      check($sformatf("rd_vld_known[%0d]", k), {31'b0, vld}, 32'd0);
      check($sformatf("gate_word[%0d]", k), word, '0);
      check($sformatf("gate_coll[%0d]", k), {31'b0, coll}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, vld0, word0, coll0);
    mon(1, vld1, word1, coll1);
  end

  task automatic step(input logic re, input logic [AW-1:0] ra, input logic we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [NL-1:0] wm,
                      input logic [DW-1:0] exp_old, input logic [DW-1:0] exp_new, input logic ec);
    exp_t e;
    @(negedge clk);
    rd_en   = re;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_word = wd;
    wr_mask = wm;
    if (re && !rst) begin
      e.data = exp_old; e.coll = ec; e.due = cyc + LAT0;
      q0.push_back(e);
      e.data = exp_new; e.due = cyc + LAT1;
      q1.push_back(e);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] m);
    step(1'b0, '0, 1'b1, a, d, m, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, a, 1'b0, '0, '0, '0, d, d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_vld0", {31'b0, vld0}, 32'd0);
    check("reset_word0", word0, '0);
    check("reset_coll0", {31'b0, coll0}, 32'd0);
    check("reset_vld1", {31'b0, vld1}, 32'd0);
    check("reset_word1", word1, '0);
    check("reset_coll1", {31'b0, coll1}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic write then read
    wr(4'd5, 32'hA5A5A5A5, 4'hF);
    rd(4'd5, 32'hA5A5A5A5);
    idle(5);

    // lane mask: zero lanes 0 and 2
    wr(4'd3, 32'hFFFFFFFF, 4'hF);
    wr(4'd3, 32'h00000000, 4'b0101);
    rd(4'd3, 32'hFF00FF00);
    idle(4);

    // collisions: same address, different address, same address with empty mask
    wr(4'd7, 32'h11111111, 4'hF);
    step(1'b1, 4'd7, 1'b1, 4'd7, 32'h22222222, 4'b0011, 32'h11111111, 32'h11112222, 1'b1);
    rd(4'd7, 32'h11112222);
    step(1'b1, 4'd7, 1'b1, 4'd8, 32'h33333333, 4'hF, 32'h11112222, 32'h11112222, 1'b0);
    step(1'b1, 4'd7, 1'b1, 4'd7, 32'h44444444, 4'b0000, 32'h11112222, 32'h11112222, 1'b0);
    rd(4'd8, 32'h33333333);
    idle(5);

    // streaming with one bubble after addr 4
    for (int i = 0; i < 10; i++) wr(AW'(i), 32'hC0DE0000 + i, 4'hF);
    for (int i = 0; i < 10; i++) begin
      rd(AW'(i), 32'hC0DE0000 + i);
      if (i == 4) idle(1);
    end
    idle(6);

    // max address and address 0 back-to-back
    wr(4'd15, 32'hAAAA5555, 4'hF);
    step(1'b1, 4'd15, 1'b1, 4'd0, 32'h5555AAAA, 4'hF, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
    rd(4'd0, 32'h5555AAAA);
    rd(4'd15, 32'hAAAA5555);
    idle(6);

    // reset while reads are in flight: outputs clear at once, in-flight reads are dropped
    for (int i = 0; i < 4; i++) rd(4'd9, 32'hC0DE0009);
    @(negedge clk);
    rd_en = 1'b1;
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("rst_async_vld0", {31'b0, vld0}, 32'd0);
    check("rst_async_word0", word0, '0);
    check("rst_async_coll0", {31'b0, coll0}, 32'd0);
    check("rst_async_vld1", {31'b0, vld1}, 32'd0);
    check("rst_async_word1", word1, '0);
    check("rst_async_coll1", {31'b0, coll1}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b0;
    idle(6);
    rd(4'd9, 32'hC0DE0009);
    rd(4'd0, 32'h5555AAAA);
    idle(8);

    check("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
